fb_write_scheduler: RTL and testbench

Owns the single framebuffer write port and shares it between the brush stream (the per-pixel address stream that paints the cursor square) and an internal screen-clear sweep engine. Sits between the cursor/brush logic and the framebuffer RAM write side. All framebuffer writes in the design pass through this block. It sequences clears, stalls the brush during a clear, drops out-of-range brush writes, and reports status.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_clear_sweep.sv | 87 ++++++++
 rtl/fb_write_scheduler.sv | 146 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer definitions.
// Used by the write scheduler, the cursor logic and the VGA read side.
//   H_RES, V_RES  : visible resolution in pixels / lines
//   FB_PIXELS     : number of framebuffer words (H_RES*V_RES)
//   ADDR_W        : linear address width (holds FB_PIXELS-1)
//   COLOR_W       : pixel data width
//   fb_addr_t     : linear pixel address (y*H_RES + x)
//   fb_color_t    : pixel value
//   fb_state_e    : write-port owner state {IDLE, BRUSH, CLEAR}
package fb_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int ADDR_W    = 20;
  localparam int COLOR_W   = 3;

  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [COLOR_W-1:0] fb_color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BRUSH = 2'd1,
    CLEAR = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_clear_sweep.sv
// fb_clear_sweep: full-screen clear engine.
// Produces one registered write per cycle, addresses 0..PIXELS-1, with the
// fill color captured at the clear request.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   latch         : capture latch_color this edge (the clear request)
//   latch_color   : fill value to capture
//   start         : (re)start the sweep at address 0 this edge
//   abort         : stop the sweep immediately, no done pulse
//   wr_en         : write strobe, high for every sweep write
//   wr_addr       : write address (the sweep counter)
//   wr_data       : write data
//   last          : the write currently on the bus is the final address
//   done          : one-cycle pulse in the cycle after the final write
module fb_clear_sweep #(
  parameter int ADDR_W  = fb_pkg::ADDR_W,
  parameter int COLOR_W = fb_pkg::COLOR_W,
  parameter int PIXELS  = fb_pkg::FB_PIXELS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               latch,
  input  logic [COLOR_W-1:0] latch_color,
  input  logic               start,
  input  logic               abort,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               last,
  output logic               done
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  logic               active;
  logic [COLOR_W-1:0] color_q;

  assign last = active && (wr_addr == LAST_ADDR);

  // The fill color is captured on the request edge; the sweep starts one
  // edge later, so a start always sees the freshly captured color. Writes
  // already in flight keep the old color until the restart edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q <= '0;
    end else if (latch) begin
      color_q <= latch_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        active  <= 1'b0;
        wr_en   <= 1'b0;
        wr_addr <= '0;
      end else if (start) begin
        // Restart takes priority over finishing, so a restarted sweep
        // yields a single done at its own end.
        active  <= 1'b1;
        wr_en   <= 1'b1;
        wr_addr <= '0;
        wr_data <= color_q;
      end else if (active) begin
        if (wr_addr == LAST_ADDR) begin
          active  <= 1'b0;
          wr_en   <= 1'b0;
          wr_addr <= '0;
          done    <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= wr_addr + 1'b1;
          wr_data <= color_q;
        end
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: owner of the single framebuffer write port.
// Shares the port between the brush stream and the clear sweep, stalls the
// brush while a clear is pending or running, and drops brush beats whose
// address lies outside the framebuffer.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   brush_valid   : brush beat offered
//   brush_ready   : brush beat accepted this cycle
//   brush_addr    : linear pixel address
//   brush_color   : pixel value
//   clear_req     : one-cycle pulse starting a full-screen clear
//   clear_color   : fill value, sampled with clear_req
//   mem_we/addr/wdata : registered framebuffer write bus
//   busy          : clear pending or sweeping
//   clear_done    : one-cycle pulse after the last clear write
//   drop_count    : saturating count of dropped out-of-range beats
//
// Brush handshake: a beat transfers on a rising edge where brush_valid and
// brush_ready are both high. brush_ready does not depend on brush_valid; it
// is low whenever a clear is requested, pending or sweeping. A transferred
// beat appears on the write bus one cycle later (mem_we only if in range).
module fb_write_scheduler #(
  parameter int H_RES   = fb_pkg::H_RES,
  parameter int V_RES   = fb_pkg::V_RES,
  parameter int ADDR_W  = fb_pkg::ADDR_W,
  parameter int COLOR_W = fb_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               brush_valid,
  output logic               brush_ready,
  input  logic [ADDR_W-1:0]  brush_addr,
  input  logic [COLOR_W-1:0] brush_color,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               clear_done,
  output logic [7:0]         drop_count
);
  import fb_pkg::*;

  localparam int PIXELS = H_RES * V_RES;
  // One extra bit so the compare is exact even if PIXELS == 2**ADDR_W.
  localparam logic [ADDR_W:0] PIXELS_W = (ADDR_W + 1)'(PIXELS);

  fb_state_e          state_q;
  fb_state_e          state_d;
  logic               clear_pending;
  logic               handshake;
  logic               in_range;

  logic               brush_we_q;
  logic [ADDR_W-1:0]  brush_addr_q;
  logic [COLOR_W-1:0] brush_data_q;

  logic               sweep_we;
  logic [ADDR_W-1:0]  sweep_addr;
  logic [COLOR_W-1:0] sweep_data;
  logic               sweep_last;
  logic               sweep_done;

  assign brush_ready = !clear_pending && (state_q != CLEAR) && !clear_req;
  assign handshake   = brush_valid && brush_ready;
  assign in_range    = ({1'b0, brush_addr} < PIXELS_W);
  assign busy        = clear_pending || (state_q == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_pending) begin
      state_d = CLEAR;
    end else begin
      unique case (state_q)
        IDLE:    if (handshake) state_d = BRUSH;
        BRUSH:   if (!brush_valid) state_d = IDLE;
        CLEAR:   if (sweep_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A request raised while one is pending simply keeps it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_pending <= 1'b0;
    end else if (clear_req) begin
      clear_pending <= 1'b1;
    end else if (clear_pending) begin
      clear_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brush_we_q   <= 1'b0;
      brush_addr_q <= '0;
      brush_data_q <= '0;
      drop_count   <= 8'd0;
    end else begin
      brush_we_q <= handshake && in_range;
      if (handshake && in_range) begin
        brush_addr_q <= brush_addr;
        brush_data_q <= brush_color;
      end
      if (handshake && !in_range && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  fb_clear_sweep #(
    .ADDR_W  (ADDR_W),
    .COLOR_W (COLOR_W),
    .PIXELS  (PIXELS)
  ) u_sweep (
    .clk         (clk),
    .rst         (reset),
    .latch       (clear_req),
    .latch_color (clear_color),
    .start       (clear_pending),
    .abort       (1'b0),
    .wr_en       (sweep_we),
    .wr_addr     (sweep_addr),
    .wr_data     (sweep_data),
    .last        (sweep_last),
    .done        (sweep_done)
  );

  // Brush and sweep writes never overlap: a brush beat cannot be accepted
  // while a clear is requested, pending or running.
  assign mem_we     = brush_we_q || sweep_we;
  assign mem_addr   = sweep_we ? sweep_addr : brush_addr_q;
  assign mem_wdata  = sweep_we ? sweep_data : brush_data_q;
  assign clear_done = sweep_done;

endmodule

// File: tb/tb_fb_write_scheduler.sv
module tb_fb_write_scheduler;
  import fb_pkg::*;

  localparam int H  = 32;
  localparam int V  = 16;
  localparam int P  = H * V;   // 512 pixels keeps full clears short
  localparam int AW = 20;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          brush_valid;
  logic          brush_ready;
  logic [AW-1:0] brush_addr;
  logic [CW-1:0] brush_color;
  logic          clear_req;
  logic [CW-1:0] clear_color;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic          busy;
  logic          clear_done;
  logic [7:0]    drop_count;

  int passed = 0;
  int total  = 0;
  int errs;
  int writes;
  int dones;

  always #5 clk = ~clk;

  fb_write_scheduler #(
    .H_RES   (H),
    .V_RES   (V),
    .ADDR_W  (AW),
    .COLOR_W (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .brush_valid (brush_valid),
    .brush_ready (brush_ready),
    .brush_addr  (brush_addr),
    .brush_color (brush_color),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .clear_done  (clear_done),
    .drop_count  (drop_count)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Accumulates one sweep-beat mismatch into errs.
  task automatic sweep_beat(input int a, input int c);
    if (!(mem_we === 1'b1 && mem_addr === AW'(a) && mem_wdata === CW'(c) && clear_done === 1'b0))
      errs++;
    if (mem_we === 1'b1) writes++;
    if (clear_done === 1'b1) dones++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    brush_valid = 1'b0; brush_addr = '0; brush_color = '0;
    clear_req = 1'b0; clear_color = '0;
    tick(); tick();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_drop_count", drop_count, 0);
    reset = 1'b0;
    tick();

    // single brush beat at (x=20, y=10)
    brush_valid = 1'b1; brush_addr = 20'(10 * H + 20); brush_color = 3'd5;
    #1 chk("b1_ready", brush_ready, 1);
    tick();
    brush_valid = 1'b0;
    chk("b1_we", mem_we, 1);
    chk("b1_addr", mem_addr, 10 * H + 20);
    chk("b1_data", mem_wdata, 5);
    tick();
    chk("b1_we_off", mem_we, 0);

    // three back-to-back beats
    for (int i = 0; i < 3; i++) begin
      brush_valid = 1'b1; brush_addr = 20'(100 + i); brush_color = 3'(3 + i);
      #1 chk("b3_ready", brush_ready, 1);
      tick();
      chk("b3_we", mem_we, 1);
      chk("b3_addr", mem_addr, 100 + i);
      chk("b3_data", mem_wdata, 3 + i);
    end
    brush_valid = 1'b0;
    tick();
    chk("b3_we_off", mem_we, 0);

    // out-of-range beats are accepted and dropped
    brush_valid = 1'b1; brush_addr = 20'(P); brush_color = 3'd1;
    #1 chk("oor_ready", brush_ready, 1);
    tick();
    chk("oor1_we", mem_we, 0);
    brush_addr = 20'd400000;
    tick();
    chk("oor2_we", mem_we, 0);
    chk("oor_drop2", drop_count, 2);
    for (int i = 0; i < 300; i++) begin
      brush_addr = 20'(P + i);
      tick();
    end
    brush_valid = 1'b0;
    chk("oor_drop_sat", drop_count, 255);
    tick();

    // clear with a brush beat offered at the same time
    brush_valid = 1'b1; brush_addr = 20'd50; brush_color = 3'd7;
    clear_req = 1'b1; clear_color = 3'd2;
    #1 chk("clr_ready_req", brush_ready, 0);
    tick();
    clear_req = 1'b0; clear_color = 3'd0;
    chk("clr_busy", busy, 1);
    chk("clr_no_brush_we", mem_we, 0);
    chk("clr_ready_pend", brush_ready, 0);
    errs = 0; writes = 0; dones = 0;
    for (int i = 0; i < P; i++) begin
      tick();
      sweep_beat(i, 2);
      if (brush_ready !== 1'b0 || busy !== 1'b1) errs++;
    end
    chk("clr_sweep_errs", errs, 0);
    chk("clr_writes", writes, P);
    tick();
    chk("clr_done", clear_done, 1);
    chk("clr_done_we", mem_we, 0);
    chk("clr_busy_off", busy, 0);
    chk("clr_ready_after", brush_ready, 1);
    tick();
    brush_valid = 1'b0;
    chk("clr_done_pulse", clear_done, 0);
    chk("post_clr_we", mem_we, 1);
    chk("post_clr_addr", mem_addr, 50);
    chk("post_clr_data", mem_wdata, 7);
    tick();

    // clear restarted after 300 writes
    clear_req = 1'b1; clear_color = 3'd1;
    tick();
    clear_req = 1'b0;
    errs = 0; writes = 0; dones = 0;
    for (int i = 0; i < 299; i++) begin
      tick();
      sweep_beat(i, 1);
    end
    clear_req = 1'b1; clear_color = 3'd4;
    tick();
    clear_req = 1'b0;
    sweep_beat(299, 1);
    for (int i = 0; i < P; i++) begin
      tick();
      sweep_beat(i, 4);
    end
    chk("rs_sweep_errs", errs, 0);
    tick();
    chk("rs_done", clear_done, 1);
    chk("rs_done_we", mem_we, 0);
    if (clear_done === 1'b1) dones++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_we === 1'b1) writes++;
      if (clear_done === 1'b1) dones++;
    end
    chk("rs_total_writes", writes, 300 + P);
    chk("rs_done_count", dones, 1);

    // reset in the middle of a sweep
    clear_req = 1'b1; clear_color = 3'd6;
    tick();
    clear_req = 1'b0;
    errs = 0; writes = 0; dones = 0;
    for (int i = 0; i <= 200; i++) begin
      tick();
      sweep_beat(i, 6);
    end
    chk("ab_sweep_errs", errs, 0);
    #2 reset = 1'b1;
    #1;
    chk("ab_we", mem_we, 0);
    chk("ab_addr", mem_addr, 0);
    chk("ab_data", mem_wdata, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", clear_done, 0);
    chk("ab_drop", drop_count, 0);
    tick();
    tick();
    chk("ab_done_held", clear_done, 0);
    reset = 1'b0;
    tick();
    chk("ab_state_idle", dut.state_q, IDLE);
    chk("ab_done_after", clear_done, 0);
    brush_valid = 1'b1; brush_addr = 20'd10; brush_color = 3'd3;
    #1 chk("ab_ready", brush_ready, 1);
    tick();
    brush_valid = 1'b0;
    chk("ab_brush_we", mem_we, 1);
    chk("ab_brush_addr", mem_addr, 10);
    chk("ab_brush_data", mem_wdata, 3);
    tick();
    chk("ab_brush_we_off", mem_we, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
